instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction decoder. Reads the 8-bit instruction stream from a synchronous instruction ROM and assembles two-byte instructions (ADDI, JEQ carry an immediate byte). Presents one instruction plus its immediate and address to decode with a valid/stall handshake. Redirects the PC when decode reports a taken branch.

## Interface
- Parameters: none; all widths are `word` (8 bits) from `project_pkg`.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  8  ROM read address (registered); ROM returns `mem[imem_addr]` on imem_rdata one cycle later
- imem_rdata  in  8  ROM read data
- stall  in  1  downstream not ready; holds the presented instruction
- pc_src  in  1  branch-taken from decode; sampled only at consume of a JEQ
- instr  out  8  current instruction byte (opcode [7:4], rs [3:2], rt [1:0])
- imm  out  8  immediate byte for ADDI/JEQ; 0x00 for single-byte instructions
- instr_pc  out  8  address of the opcode byte of `instr`
- instr_valid  out  1  instr/imm/instr_pc are valid

## Operation
- Two-byte opcodes: ADDI (4'h2), JEQ (4'hC). All other opcodes are single-byte, including undefined ones.
- Internal `pc` holds the address of the next byte to request. 8-bit, wraps 0xFF -> 0x00 with no flag.
- FSM states: BOOT, OP, IMM, ISSUE.
- BOOT: imem_addr = 0x00; pc <= 0x01; -> OP.
- OP: imem_rdata is the opcode byte at pc-1.
  - Two-byte opcode: latch opcode internally; imem_addr <= pc; pc <= pc+1; -> IMM.
  - Otherwise: instr <= rdata, imm <= 0x00, instr_pc <= pc-1; -> ISSUE.
- IMM: instr <= latched opcode, imm <= rdata, instr_pc <= address of opcode; -> ISSUE.
- ISSUE: instr_valid = 1.
  - stall = 1: hold all outputs and state; pc_src is ignored.
  - stall = 0 (consume):
    - If instr[7:4] == JEQ and pc_src = 1: imem_addr <= imm; pc <= imm+1.
    - Otherwise: imem_addr <= pc; pc <= pc+1.
    - -> OP.
- pc_src is ignored for every opcode other than JEQ.
- JEQ target is absolute, equal to imm.
- Branch to 0xFF: imem_addr = 0xFF, pc <= 0x00.
- A two-byte instruction whose opcode sits at 0xFF takes its immediate from 0x00.

## Timing
- Reset values, from the cycle after rst is sampled high: state BOOT, pc 0x00, imem_addr 0x00, instr 0x00 (NOP), imm 0x00, instr_pc 0x00, instr_valid 0.
- rst in any state, including mid two-byte fetch or during stall, aborts the operation. No partial instruction is ever presented afterwards.
- instr/imm/instr_pc change only on entry to ISSUE. They are stable while instr_valid = 1.
- instr_valid is high only in ISSUE. It drops in the cycle after a consume.
- First instr_valid: 2 cycles after rst deasserts for a single-byte opcode at 0x00, 3 cycles for a two-byte opcode.
- Throughput with stall = 0: single-byte instruction every 2 cycles; two-byte every 3 cycles.
- Branch penalty: none beyond normal sequencing. The target opcode is in OP in the cycle after consume, identical to sequential fetch.
- Outputs are registered; pc_src and stall reach only the next-state logic, with no combinational path to any output.

## Test plan
- Reset and first fetch: ROM[0]=0x10, rst high 2 cycles then low -> cycle 1: state OP; cycle 2: instr_valid=1, instr=0x10, imm=0x00, instr_pc=0x00; all outputs 0 during reset.
- Mixed stream, stall=0: ROM = 10,25,7A,30 -> issues in order:
  - (0x10, imm 00, pc 00)
  - (0x25, imm 7A, pc 01)
  - (0x30, imm 00, pc 03)
  - valid pulses 2, 3, 2 cycles apart.
- JEQ taken: ROM[4]=C0, ROM[5]=10, ROM[0x10]=40; pc_src=1 at consume -> next issue instr=0x40, instr_pc=0x10. Same with pc_src=0 -> next instr_pc=0x06.
- pc_src on non-JEQ: ROM[0]=10 (ADD) with pc_src=1 at consume -> next instr_pc=0x01; no redirect.
- Stall: stall=1 for 5 cycles while ISSUE holds ADDI 0x2, imm 0x33, toggling pc_src:
  - instr/imm/instr_pc/instr_valid and imem_addr remain constant.
  - Release -> next instr_pc = 0x02 above the ADDI address.
- Wrap and reset mid-op:
  - ROM[FF]=25, ROM[00]=44 -> issue instr=0x25, imm=0x44, instr_pc=0xFF.
  - rst asserted in IMM -> all outputs 0, refetch from 0x00.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Shared width package and the fetch-stage bus interface.
//
// project_pkg : defines `word`, the 8-bit datapath width used by the stage.
// instr_fetch_if : groups the instruction-ROM port and the decode handshake.
//   imem_addr   fetch -> ROM     registered read address
//   imem_rdata  ROM   -> fetch   byte at the current imem_addr
//   stall       decode -> fetch  decode not ready; presented instruction held
//   pc_src      decode -> fetch  branch taken, used only when a JEQ is consumed
//   instr       fetch -> decode  opcode byte {opcode[7:4], rs[3:2], rt[1:0]}
//   imm         fetch -> decode  immediate byte, 0x00 for single-byte opcodes
//   instr_pc    fetch -> decode  address of the opcode byte
//   instr_valid fetch -> decode  instr/imm/instr_pc are valid
//
// Handshake: fetch raises instr_valid with instr/imm/instr_pc stable; the
// instruction is consumed on a rising clk edge where instr_valid=1 and stall=0.
// While stall=1 nothing moves and pc_src is ignored. instr_valid drops in the
// cycle after a consume.
// master = fetch stage, slave = ROM/decode side.

package project_pkg;
    typedef logic [7:0] word;
endpackage

interface instr_fetch_if;
    import project_pkg::*;

    word  imem_addr;
    word  imem_rdata;
    logic stall;
    logic pc_src;
    word  instr;
    word  imm;
    word  instr_pc;
    logic instr_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  pc_src,
        output instr,
        output imm,
        output instr_pc,
        output instr_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output pc_src,
        input  instr,
        input  imm,
        input  instr_pc,
        input  instr_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the decoder.
//
// Reads bytes from an instruction ROM addressed by the registered imem_addr
// (imem_rdata is the byte at the address register's current value), joins
// ADDI/JEQ opcodes with their immediate byte, and presents one instruction at
// a time on the decode handshake. A consumed JEQ with pc_src=1 redirects the
// fetch to the absolute address held in its immediate.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   bus        instr_fetch_if.master (ROM port + decode handshake)
//   fsm_state  current FSM state for observation (0 BOOT, 1 OP, 2 IMM, 3 ISSUE)

module instr_fetch
    import project_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instr_fetch_if.master       bus,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        OP    = 2'd1,
        IMM   = 2'd2,
        ISSUE = 2'd3
    } state_t;

    localparam logic [3:0] OPC_ADDI = 4'h2;
    localparam logic [3:0] OPC_JEQ  = 4'hC;

    state_t state, state_n;
    word    pc, pc_n;            // address of the next byte to request
    word    addr_q, addr_n;      // drives imem_addr
    word    op_q, op_n;          // opcode held while its immediate is fetched
    word    op_pc_q, op_pc_n;    // address of that held opcode
    word    instr_q, instr_n;
    word    imm_q, imm_n;
    word    ipc_q, ipc_n;

    function automatic logic is_two_byte(input word op);
        return (op[7:4] == OPC_ADDI) || (op[7:4] == OPC_JEQ);
    endfunction

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= 8'h00;
            addr_q  <= 8'h00;
            op_q    <= 8'h00;
            op_pc_q <= 8'h00;
            instr_q <= 8'h00;
            imm_q   <= 8'h00;
            ipc_q   <= 8'h00;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            addr_q  <= addr_n;
            op_q    <= op_n;
            op_pc_q <= op_pc_n;
            instr_q <= instr_n;
            imm_q   <= imm_n;
            ipc_q   <= ipc_n;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr_q;
        op_n    = op_q;
        op_pc_n = op_pc_q;
        instr_n = instr_q;
        imm_n   = imm_q;
        ipc_n   = ipc_q;

        case (state)
            BOOT: begin
                addr_n  = 8'h00;
                pc_n    = 8'h01;
                state_n = OP;
            end
            OP: begin
                // imem_rdata holds the opcode byte at pc-1 here
                if (is_two_byte(bus.imem_rdata)) begin
                    op_n    = bus.imem_rdata;
                    op_pc_n = pc - 8'h01;
                    addr_n  = pc;            // wraps naturally: opcode at 0xFF reads 0x00
                    pc_n    = pc + 8'h01;
                    state_n = IMM;
                end else begin
                    instr_n = bus.imem_rdata;
                    imm_n   = 8'h00;
                    ipc_n   = pc - 8'h01;
                    state_n = ISSUE;
                end
            end
            IMM: begin
                instr_n = op_q;
                imm_n   = bus.imem_rdata;
                ipc_n   = op_pc_q;
                state_n = ISSUE;
            end
            ISSUE: begin
                if (!bus.stall) begin
                    // Redirect keeps the same OP-next-cycle timing as a sequential fetch
                    if ((instr_q[7:4] == OPC_JEQ) && bus.pc_src) begin
                        addr_n = imm_q;
                        pc_n   = imm_q + 8'h01;
                    end else begin
                        addr_n = pc;
                        pc_n   = pc + 8'h01;
                    end
                    state_n = OP;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // Outputs: all taken from registers, so stall/pc_src never reach them combinationally
    always_comb begin
        bus.imem_addr   = addr_q;
        bus.instr       = instr_q;
        bus.imm         = imm_q;
        bus.instr_pc    = ipc_q;
        bus.instr_valid = (state == ISSUE);
        fsm_state       = state;
    end

endmodule
